debug_reg_dumper: RTL
=====================

Name: debug_reg_dumper

Overview:
- Host-side reader for the computer's register-debug port.
- On a start pulse it drives `debug_reg_select` through registers 0..NUM_REGS-1 and waits for the combinational read to settle.
- It captures each `debug_reg_out` value and streams it as bytes, least-significant byte first, over a valid/ready byte interface.
- It sits beside the single-cycle computer and feeds a UART or trace transmitter.

Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); must be ≤ 2^SEL_W.
- SEL_W, 5, width of `debug_reg_select`.
- SETTLE_CYCLES, 1, cycles a select value is held before capture; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle request to begin a dump; ignored unless IDLE.
- debug_reg_select  output  SEL_W  register index driven to the computer.
- debug_reg_out  input  32  register value returned by the computer.
- fetchPC  input  32  computer PC; used only with the optional feature.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts a byte when out_valid & out_ready.
- out_last  output  1  high with the final byte of a dump.
- busy  output  1  high in any state other than IDLE.
- done  output  1  1-cycle pulse after the final byte handshake.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - debug_reg_select = 0, out_data = 0.
  - out_valid, out_last, busy, done = 0.
  - Capture register = 0, byte counter = 0, settle counter = 0.
- State machine:
  - IDLE: start=1 at an edge → SETTLE with select=0, settle counter = SETTLE_CYCLES-1. busy rises in the same cycle as SETTLE.
  - SETTLE: select held constant. When counter = 0 → CAPTURE, otherwise decrement.
  - CAPTURE: capture register ← debug_reg_out; byte counter ← 0 → SEND.
  - SEND: out_valid=1 and out_data = capture[8*k+7:8*k] for k = byte counter.
    - On handshake with k < 3: k ← k+1.
    - On handshake with k = 3 and word not last: select ← select+1, reload settle counter → SETTLE.
    - On handshake with k = 3 and word last: → DONE.
  - DONE: done=1 and busy=1 for exactly one cycle → IDLE; select returns to 0.
- Handshake rules:
  - While out_valid & !out_ready, out_data and out_last stay stable and out_valid stays high. No byte is ever dropped or duplicated.
  - out_valid is registered and never depends combinationally on out_ready.
- Timing: minimum per-register latency is SETTLE_CYCLES + 1 (capture) + 4 byte cycles. A dump with out_ready tied high and SETTLE_CYCLES=1 takes NUM_REGS*6 cycles from the first SETTLE cycle to the last handshake.
- out_last = 1 only in SEND, when k = 3 and the current word is the last word.
- start while busy (including in DONE) is ignored and not queued.
- Select wrap-around: select never exceeds NUM_REGS-1. The end of the dump is detected by comparing against NUM_REGS-1, not by counter overflow.
- Reset mid-dump: immediate return to reset values. A partially sent word is abandoned; the sink sees out_valid fall.

Optional Feature:
- Macro: DEBUG_DUMP_PC_EN.
- Defined:
  - After register NUM_REGS-1, a further word is appended: fetchPC, sampled in CAPTURE one cycle after a SETTLE cycle, sent as 4 bytes LSB first.
  - out_last moves to byte 3 of the PC word; each dump is (NUM_REGS+1)*4 bytes.
  - debug_reg_select holds NUM_REGS-1 during the PC word.
- Undefined: fetchPC is unused and each dump is NUM_REGS*4 bytes.

Test Plan:
- Reset/idle: assert reset mid-SEND of reg 5 → outputs zero immediately; after release busy=0, and start produces a full dump from reg 0.
- Full dump, out_ready=1, reg[i] = 0xA5000000+i, SETTLE_CYCLES=1, macro undefined:
  - Exactly 128 bytes in order 0x00,0x00,0x00,0xA5,0x01,0x00,0x00,0xA5,…
  - out_last only on byte 127; done one cycle later; total 192 cycles to the last handshake.
- Back-pressure: out_ready random 30% duty → byte sequence identical to the previous test; out_data stable on every stalled cycle.
- start pulsed during busy at reg 10 and in DONE → no second dump; byte count remains 128.
- SETTLE_CYCLES=3: select changes, then capture occurs after exactly 3 stable cycles; checked against a model where the read value changes one cycle after select.
- DEBUG_DUMP_PC_EN defined, fetchPC=0x00000040 → 132 bytes; last four bytes 0x40,0x00,0x00,0x00; out_last on byte 131.

Source files
------------

// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks debug_reg_select over every register, captures each value and
// streams it LSB-first on a valid/ready byte port. Define DEBUG_DUMP_PC_EN to append fetchPC.
module debug_reg_dumper #(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned SEL_W         = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SEL_W-1:0] debug_reg_select,
  input  logic [31:0]      debug_reg_out,
  input  logic [31:0]      fetchPC,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL      = SEL_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] settle_q;
  logic [31:0]      capture_q;
  logic [1:0]       byte_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;

  logic             hs;
  logic             last_word;
  logic [31:0]      word_in;
  logic [1:0]       byte_nxt;

  assign hs       = valid_q & out_ready;
  assign byte_nxt = byte_q + 2'd1;

  // The word being sent is final either at the last register or, with the PC word, after it.
`ifdef DEBUG_DUMP_PC_EN
  logic pc_word_q;
  assign last_word = pc_word_q;
  assign word_in   = pc_word_q ? fetchPC : debug_reg_out;
`else
  logic unused_pc;
  assign unused_pc = ^fetchPC;
  assign last_word = (sel_q == LAST_SEL);
  assign word_in   = debug_reg_out;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      settle_q  <= '0;
      capture_q <= '0;
      byte_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DEBUG_DUMP_PC_EN
      pc_word_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SETTLE;
            sel_q    <= '0;
            settle_q <= SETTLE_RELOAD;
            busy_q   <= 1'b1;
          end
        end

        SETTLE: begin
          if (settle_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            settle_q <= settle_q - CNT_W'(1);
          end
        end

        // First byte is loaded straight from the input so it is valid on entry to SEND.
        CAPTURE: begin
          capture_q <= word_in;
          byte_q    <= '0;
          data_q    <= word_in[7:0];
          valid_q   <= 1'b1;
          last_q    <= 1'b0;
          state_q   <= SEND;
        end

        SEND: begin
          if (hs) begin
            if (byte_q != 2'd3) begin
              byte_q <= byte_nxt;
              data_q <= capture_q[{byte_nxt, 3'b000} +: 8];
              last_q <= (byte_nxt == 2'd3) && last_word;
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (last_word) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q  <= SETTLE;
                settle_q <= SETTLE_RELOAD;
`ifdef DEBUG_DUMP_PC_EN
                if (sel_q == LAST_SEL) begin
                  pc_word_q <= 1'b1;
                end else begin
                  sel_q <= sel_q + SEL_W'(1);
                end
`else
                sel_q <= sel_q + SEL_W'(1);
`endif
              end
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          sel_q   <= '0;
`ifdef DEBUG_DUMP_PC_EN
          pc_word_q <= 1'b0;
`endif
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign debug_reg_select = sel_q;
  assign out_data         = data_q;
  assign out_valid        = valid_q;
  assign out_last         = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
